perf_counter_update: RTL and testbench
======================================

Name: perf_counter_update

Overview:
Update and access logic that drives the ten-register performance counter bank. Each cycle it takes one-cycle event strobes from the pipeline and caches. From the bank's current outputs it computes saturating next values and issues per-counter load/in pairs. It also exposes the bank plus an enable/clear control word to software through a memory-mapped window, using the standard LC-3b mem_read/mem_write/mem_resp handshake.

Parameters:
PERF_BASE, 16'hFFE0, word-aligned base address of the counter window.
NUM_CTRS, 10, number of counters; fixed, not for override.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ev_in  in  9  event strobes, one bit per event, bit order per perf_idx_t: branch, branch_mispred, stall, l1_hit, l2_hit, evict_hit, l1_miss, l2_miss, evict_miss
ctr_out  in  10 x lc3b_word  current value of each counter register, perf_idx_t order; index 9 = curr_stall
ctr_load  out  10  per-counter load enable
ctr_in  out  10 x lc3b_word  per-counter next value
mem_read  in  1  software read request
mem_write  in  1  software write request
mem_address  in  lc3b_word  byte address
mem_wdata  in  lc3b_word  write data
mem_rdata  out  lc3b_word  read data, valid while mem_resp=1
mem_resp  out  1  one-cycle completion pulse

Behaviour:
- Reset (reset=1 at an edge): ev_q=0, enable=1, FSM=IDLE, mem_resp=0, mem_rdata=0. While reset=1, ctr_load is all ones and ctr_in is all zero, so the bank clears on every reset edge.
- Event pipe: ev_in is registered into ev_q every cycle, whatever the value of enable.
  - Event at cycle N is visible in ctr_out at cycle N+2.
- Increment, for counters 0..8 when enable=1 and ev_q[i]=1:
  - ctr_load[i]=1, ctr_in[i]=ctr_out[i]+1.
  - Saturate: at 16'hFFFF, ctr_in stays 16'hFFFF.
- curr_stall (index 9), when enable=1:
  - ev_q.stall=1 -> saturating increment.
  - ev_q.stall=0 and ctr_out[9]!=0 -> load 0.
  - Otherwise no load.
- enable=0: no increment or curr_stall loads. Software clears still apply.
- Window decode: hit when mem_address is in PERF_BASE .. PERF_BASE+2*NUM_CTRS+1. Offset = (mem_address-PERF_BASE)>>1.
  - Offsets 0..9 address counters.
  - Offset 10 is CTRL: bit0 = enable, bit1 = clear-all (write-only pulse, reads 0, not stored).
- Out-of-window requests are ignored: no resp, no side effect.
- FSM IDLE -> ACK when (mem_read|mem_write) and hit. ACK -> IDLE unconditionally.
  - mem_resp=1 only in ACK.
  - The master drops its request on the edge it sees resp, so a held request is not re-accepted.
- Actions on the IDLE->ACK edge:
  - Read counter: mem_rdata <= ctr_out[off].
  - Read CTRL: mem_rdata <= {14'b0, 1'b0, enable}.
  - Write counter: clear that counter (write data ignored).
  - Write CTRL: enable <= wdata[0]; if wdata[1]=1, clear all 10 counters.
  - Read and write both high: write takes priority; mem_rdata = 0.
- Clear vs. increment on the same edge: the clear wins (load with 0) and that cycle's event is lost.
- Read concurrent with an increment: returns the pre-increment value.
- reset in ACK: returns to IDLE, mem_resp drops next cycle, any clear already applied stays applied.

Decomposition:
- lc3b_types gains:
  - perf_idx_t, an enum for the 10 counter indices.
  - PERF_BASE default and PERF_CTRL_OFF = 10.
  - A packed perf_events_t struct for ev_in.
- One sub-module, perf_sat_inc (lc3b_word in -> saturating +1 out), is instantiated 10 times.
- The FSM and decode stay in the top module.

Test Plan:
- Reset, then drive ev_in.branch=1 for 3 cycles -> ctr_out[branch] steps 1,2,3 starting 2 cycles after the first strobe; other counters stay 0.
- Preload l1_miss to 16'hFFFE, drive 3 l1_miss strobes -> value reaches 16'hFFFF and stays there.
- stall=1 for 5 cycles then 0 -> curr_stall reaches 5 then 0 one cycle after the drop; the stall counter holds 5.
- mem_read at PERF_BASE+4 with stall=7 -> mem_resp pulses one cycle later, mem_rdata=7. A read at PERF_BASE+40 gets no resp.
- Write 16'h0000 to PERF_BASE+20, then 4 branch strobes -> branch stays 0. Write 16'h0003 -> enable=1 and all counters 0, including a counter receiving an event on that same edge.
- Assert reset during ACK of a CTRL write -> FSM returns to IDLE, enable=1, all counters 0.

Source files
------------

// File: rtl/perf_counter_update_pkg.sv
// Shared LC-3b types plus the performance counter bank definitions:
// counter indices, event strobe layout, window constants and FSM states.
package perf_counter_update_pkg;

    typedef logic [15:0] lc3b_word;

    localparam int NUM_CTRS   = 10;
    localparam int NUM_EVENTS = 9;

    localparam lc3b_word   PERF_BASE_DEFAULT = 16'hFFE0;
    localparam logic [3:0] PERF_CTRL_OFF     = 4'd10;

    typedef enum logic [3:0] {
        PERF_BRANCH         = 4'd0,
        PERF_BRANCH_MISPRED = 4'd1,
        PERF_STALL          = 4'd2,
        PERF_L1_HIT         = 4'd3,
        PERF_L2_HIT         = 4'd4,
        PERF_EVICT_HIT      = 4'd5,
        PERF_L1_MISS        = 4'd6,
        PERF_L2_MISS        = 4'd7,
        PERF_EVICT_MISS     = 4'd8,
        PERF_CURR_STALL     = 4'd9
    } perf_idx_t;

    // Declared MSB first so that bit 0 is branch, matching perf_idx_t.
    typedef struct packed {
        logic evict_miss;
        logic l2_miss;
        logic l1_miss;
        logic evict_hit;
        logic l2_hit;
        logic l1_hit;
        logic stall;
        logic branch_mispred;
        logic branch;
    } perf_events_t;

    typedef enum logic {
        PERF_IDLE = 1'b0,
        PERF_ACK  = 1'b1
    } perf_state_t;

    // Byte address of counter idx inside a window starting at base.
    function automatic lc3b_word perf_addr(input lc3b_word base, input int idx);
        return base + lc3b_word'(2 * idx);
    endfunction

endpackage

// File: rtl/perf_counter_update_sat_inc.sv
// Saturating +1 on one counter word: all-ones stays all-ones.
module perf_sat_inc
    import perf_counter_update_pkg::*;
(
    input  lc3b_word value,
    output lc3b_word value_inc
);

    // Increment unless already at the ceiling.
    always_comb begin
        value_inc = (value == 16'hFFFF) ? value : value + 16'd1;
    end

endmodule

// File: rtl/perf_counter_update.sv
// Update and software access logic for the ten-register performance
// counter bank. Event strobes are registered once, then turned into
// saturating load/in pairs for the bank; a small memory-mapped window
// lets software read counters, clear them and control counting.
//
// Bus handshake: a request (mem_read or mem_write held high) is accepted
// in IDLE when its address hits the window; the next cycle is ACK, where
// mem_resp is high for exactly one cycle and mem_rdata is valid. The
// master drops its request on the edge it sees mem_resp, and ACK always
// returns to IDLE, so a request is never accepted twice. Misses get no
// response at all.
module perf_counter_update
    import perf_counter_update_pkg::*;
#(
    parameter lc3b_word PERF_BASE = PERF_BASE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_EVENTS-1:0] ev_in,
    input  lc3b_word              ctr_out [NUM_CTRS],
    output logic [NUM_CTRS-1:0]   ctr_load,
    output lc3b_word              ctr_in [NUM_CTRS],
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  lc3b_word              mem_address,
    input  lc3b_word              mem_wdata,
    output lc3b_word              mem_rdata,
    output logic                  mem_resp,
    output perf_state_t           fsm_state
);

    perf_events_t          ev_q;
    logic [NUM_EVENTS-1:0] ev_bits;
    logic                  enable;
    perf_state_t           state, state_next;
    logic                  accept;
    lc3b_word              delta;
    logic                  hit;
    logic [3:0]            offset;
    logic [NUM_CTRS-1:0]   sw_clear;
    lc3b_word              sat [NUM_CTRS];
    logic                  unused_wdata_bits;

    assign ev_bits           = ev_q;
    assign unused_wdata_bits = ^mem_wdata[15:2];

    assign delta  = mem_address - PERF_BASE;
    assign hit    = (mem_address >= PERF_BASE) && (delta <= lc3b_word'(2 * NUM_CTRS + 1));
    assign offset = delta[4:1];

    assign mem_resp  = (state == PERF_ACK);
    assign fsm_state = state;

    for (genvar g = 0; g < NUM_CTRS; g++) begin : g_inc
        perf_sat_inc u_inc (
            .value     (ctr_out[g]),
            .value_inc (sat[g])
        );
    end

    // Access FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= PERF_IDLE;
        else       state <= state_next;
    end

    // Next state and request acceptance: accept only hits while idle.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            PERF_IDLE: begin
                if ((mem_read || mem_write) && hit) begin
                    accept     = 1'b1;
                    state_next = PERF_ACK;
                end
            end
            PERF_ACK:  state_next = PERF_IDLE;
            default:   state_next = PERF_IDLE;
        endcase
    end

    // Software clears: single counter write, or CTRL write with clear-all.
    always_comb begin
        sw_clear = '0;
        if (accept && mem_write) begin
            if (offset == PERF_CTRL_OFF) begin
                if (mem_wdata[1]) sw_clear = '1;
            end else begin
                sw_clear[offset] = 1'b1;
            end
        end
    end

    // Event register, enable bit and read data capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            ev_q      <= '0;
            enable    <= 1'b1;
            mem_rdata <= '0;
        end else begin
            ev_q <= perf_events_t'(ev_in);
            if (accept) begin
                if (mem_write) begin
                    mem_rdata <= '0;
                    if (offset == PERF_CTRL_OFF) enable <= mem_wdata[0];
                end else if (offset == PERF_CTRL_OFF) begin
                    mem_rdata <= {15'b0, enable};
                end else begin
                    mem_rdata <= ctr_out[offset];
                end
            end
        end
    end

    // Bank load/in pairs: reset clears all, clears override increments.
    always_comb begin
        ctr_load = '0;
        for (int i = 0; i < NUM_CTRS; i++) ctr_in[i] = '0;
        if (reset) begin
            ctr_load = '1;
        end else begin
            if (enable) begin
                for (int i = 0; i < NUM_EVENTS; i++) begin
                    if (ev_bits[i]) begin
                        ctr_load[i] = 1'b1;
                        ctr_in[i]   = sat[i];
                    end
                end
                // curr_stall tracks the length of the ongoing stall run.
                if (ev_q.stall) begin
                    ctr_load[PERF_CURR_STALL] = 1'b1;
                    ctr_in[PERF_CURR_STALL]   = sat[PERF_CURR_STALL];
                end else if (ctr_out[PERF_CURR_STALL] != 16'h0000) begin
                    ctr_load[PERF_CURR_STALL] = 1'b1;
                    ctr_in[PERF_CURR_STALL]   = '0;
                end
            end
            for (int i = 0; i < NUM_CTRS; i++) begin
                if (sw_clear[i]) begin
                    ctr_load[i] = 1'b1;
                    ctr_in[i]   = '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_perf_counter_update.sv
// Bench for perf_counter_update: models the counter bank around the
// DUT, runs a table of event patterns and hand-built bus sequences.
module tb_perf_counter_update;
  import perf_counter_update_pkg::*;

  localparam logic [8:0] EV_BRANCH = 9'h001;
  localparam logic [8:0] EV_STALL  = 9'h004;
  localparam logic [8:0] EV_L1HIT  = 9'h008;
  localparam logic [8:0] EV_L1MISS = 9'h040;
  localparam lc3b_word A_BRANCH = 16'hFFE0;
  localparam lc3b_word A_MISP   = 16'hFFE2;
  localparam lc3b_word A_STALL  = 16'hFFE4;
  localparam lc3b_word A_L1HIT  = 16'hFFE6;
  localparam lc3b_word A_CTRL   = 16'hFFF4;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [8:0]   ev_in;
  lc3b_word     bank [NUM_CTRS];
  logic [9:0]   ctr_load;
  lc3b_word     ctr_in [NUM_CTRS];
  logic         mem_read, mem_write;
  lc3b_word     mem_address, mem_wdata, mem_rdata;
  logic         mem_resp;
  perf_state_t  fsm_state;
  logic         pre_en;
  int           pre_idx;
  lc3b_word     pre_val;

  perf_counter_update dut (
    .clk         (clk),
    .reset       (reset),
    .ev_in       (ev_in),
    .ctr_out     (bank),
    .ctr_load    (ctr_load),
    .ctr_in      (ctr_in),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp),
    .fsm_state   (fsm_state)
  );

  // counter bank model with a preload port for corner cases
  always @(posedge clk) begin
    if (pre_en) bank[pre_idx] <= pre_val;
    for (int i = 0; i < NUM_CTRS; i++)
      if (ctr_load[i]) bank[i] <= ctr_in[i];
  end

  // scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];
  logic [47:0] cnt_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_bank_zero(input string name);
    for (int i = 0; i < NUM_CTRS; i++)
      check($sformatf("%s_%0d", name, i), {16'h0, bank[i]}, 32'h0);
  endtask

  // driver: one bus access, bounded wait for the response
  task automatic mem_access(input logic rd, input logic wr, input lc3b_word addr,
                            input lc3b_word wdata, input logic exp_resp,
                            input lc3b_word exp_rdata, input string name);
    int lat;
    logic got;
    logic [15:0] e;
    if (exp_resp && rd) exp_q.push_back(exp_rdata);
    mem_read = rd; mem_write = wr; mem_address = addr; mem_wdata = wdata;
    got = 1'b0; lat = 0;
    while (!got && lat < 4) begin
      @(negedge clk);
      lat++;
      if (mem_resp) got = 1'b1;
    end
    mem_read = 1'b0; mem_write = 1'b0;
    if (exp_resp) begin
      check({name, "_resp"}, {31'b0, got}, 32'h1);
      check({name, "_lat"}, lat, 1);
      if (rd && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (got) check({name, "_rdata"}, {16'h0, mem_rdata}, {16'h0, e});
      end
    end else begin
      check({name, "_noresp"}, {31'b0, got}, 32'h0);
    end
    @(negedge clk);
    check({name, "_pulse"}, {31'b0, mem_resp}, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; ev_in = '0; mem_read = 1'b0; mem_write = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [8:0] ev;
    lc3b_word   exp_branch;
    lc3b_word   exp_stall;
    lc3b_word   exp_curr;
  } vec_t;
  vec_t tbl [8];

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [47:0] e;
    logic        any_in;
    tbl[0] = '{EV_BRANCH | EV_STALL, 16'd1, 16'd1, 16'd1};
    tbl[1] = '{EV_STALL,             16'd1, 16'd2, 16'd2};
    tbl[2] = '{EV_BRANCH,            16'd2, 16'd2, 16'd0};
    tbl[3] = '{9'h000,               16'd2, 16'd2, 16'd0};
    tbl[4] = '{EV_BRANCH | EV_STALL, 16'd3, 16'd3, 16'd1};
    tbl[5] = '{EV_STALL,             16'd3, 16'd4, 16'd2};
    tbl[6] = '{EV_BRANCH | EV_L1HIT, 16'd4, 16'd4, 16'd0};
    tbl[7] = '{EV_STALL,             16'd4, 16'd5, 16'd1};

    reset = 1'b1; ev_in = '0; mem_read = 1'b0; mem_write = 1'b0;
    mem_address = '0; mem_wdata = '0; pre_en = 1'b0; pre_idx = 0; pre_val = '0;

    // reset state
    @(negedge clk);
    check("rst_load", {22'b0, ctr_load}, 32'h3FF);
    any_in = 1'b0;
    for (int i = 0; i < NUM_CTRS; i++) if (ctr_in[i] != 16'h0) any_in = 1'b1;
    check("rst_in_zero", {31'b0, any_in}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    check("rst_resp", {31'b0, mem_resp}, 32'h0);
    check("rst_rdata", {16'h0, mem_rdata}, 32'h0);
    check("rst_fsm", {31'b0, fsm_state}, {31'b0, PERF_IDLE});
    check_bank_zero("rst_bank");
    mem_access(1'b1, 1'b0, A_CTRL, 16'h0, 1'b1, 16'h0001, "rst_ctrl");

    // table-driven event patterns, each visible two cycles later
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (cnt_q.size() == 2) begin
        e = cnt_q.pop_front();
        check($sformatf("tbl_branch_%0d", k - 2), {16'h0, bank[PERF_BRANCH]}, {16'h0, e[47:32]});
        check($sformatf("tbl_stall_%0d", k - 2), {16'h0, bank[PERF_STALL]}, {16'h0, e[31:16]});
        check($sformatf("tbl_curr_%0d", k - 2), {16'h0, bank[PERF_CURR_STALL]}, {16'h0, e[15:0]});
      end
      ev_in = tbl[k].ev;
      cnt_q.push_back({tbl[k].exp_branch, tbl[k].exp_stall, tbl[k].exp_curr});
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      ev_in = '0;
      e = cnt_q.pop_front();
      check($sformatf("tbl_branch_%0d", k + 6), {16'h0, bank[PERF_BRANCH]}, {16'h0, e[47:32]});
      check($sformatf("tbl_stall_%0d", k + 6), {16'h0, bank[PERF_STALL]}, {16'h0, e[31:16]});
      check($sformatf("tbl_curr_%0d", k + 6), {16'h0, bank[PERF_CURR_STALL]}, {16'h0, e[15:0]});
    end
    repeat (2) @(negedge clk);
    mem_access(1'b1, 1'b0, A_L1HIT,  16'h0, 1'b1, 16'd1, "rd_l1hit");
    mem_access(1'b1, 1'b0, A_MISP,   16'h0, 1'b1, 16'd0, "rd_misp");
    mem_access(1'b1, 1'b0, A_BRANCH, 16'h0, 1'b1, 16'd4, "rd_branch");

    // saturation on l1_miss
    pre_en = 1'b1; pre_idx = PERF_L1_MISS; pre_val = 16'hFFFE;
    @(negedge clk);
    pre_en = 1'b0;
    ev_in = EV_L1MISS;
    @(negedge clk);
    ev_in = EV_L1MISS;
    @(negedge clk);
    check("sat_first", {16'h0, bank[PERF_L1_MISS]}, 32'hFFFF);
    ev_in = EV_L1MISS;
    @(negedge clk);
    ev_in = '0;
    check("sat_second", {16'h0, bank[PERF_L1_MISS]}, 32'hFFFF);
    repeat (3) @(negedge clk);
    check("sat_hold", {16'h0, bank[PERF_L1_MISS]}, 32'hFFFF);

    // stall run of five, then drop
    do_reset();
    for (int k = 0; k < 5; k++) begin
      ev_in = EV_STALL;
      @(negedge clk);
    end
    ev_in = '0;
    @(negedge clk);
    check("run_curr5", {16'h0, bank[PERF_CURR_STALL]}, 32'd5);
    check("run_stall5", {16'h0, bank[PERF_STALL]}, 32'd5);
    @(negedge clk);
    check("run_curr0", {16'h0, bank[PERF_CURR_STALL]}, 32'd0);
    check("run_stall_hold", {16'h0, bank[PERF_STALL]}, 32'd5);
    ev_in = EV_STALL;
    @(negedge clk);
    @(negedge clk);
    ev_in = '0;
    repeat (3) @(negedge clk);

    // window decode and boundaries
    mem_access(1'b1, 1'b0, A_STALL, 16'h0, 1'b1, 16'd7, "rd_stall7");
    mem_access(1'b1, 1'b0, 16'h0008, 16'h0, 1'b0, 16'h0, "rd_base40");
    mem_access(1'b1, 1'b0, 16'hFFF6, 16'h0, 1'b0, 16'h0, "rd_above");
    mem_access(1'b1, 1'b0, 16'hFFDE, 16'h0, 1'b0, 16'h0, "rd_below");
    mem_access(1'b1, 1'b0, 16'hFFF5, 16'h0, 1'b1, 16'h0001, "rd_ctrl_top");

    // disable, events ignored
    mem_access(1'b0, 1'b1, A_CTRL, 16'h0000, 1'b1, 16'h0, "wr_dis");
    for (int k = 0; k < 4; k++) begin
      ev_in = EV_BRANCH | EV_STALL;
      @(negedge clk);
    end
    ev_in = '0;
    repeat (3) @(negedge clk);
    check("dis_branch", {16'h0, bank[PERF_BRANCH]}, 32'd0);
    check("dis_stall", {16'h0, bank[PERF_STALL]}, 32'd7);
    mem_access(1'b1, 1'b0, A_CTRL, 16'h0, 1'b1, 16'h0000, "rd_ctrl_dis");

    // re-enable, then clear-all colliding with an increment
    mem_access(1'b0, 1'b1, A_CTRL, 16'h0001, 1'b1, 16'h0, "wr_en");
    ev_in = EV_BRANCH;
    @(negedge clk);
    ev_in = '0;
    mem_access(1'b0, 1'b1, A_CTRL, 16'h0003, 1'b1, 16'h0, "wr_clr");
    repeat (2) @(negedge clk);
    check_bank_zero("clr_all");
    mem_access(1'b1, 1'b0, A_CTRL, 16'h0, 1'b1, 16'h0001, "rd_ctrl_en");

    // single-counter clear and read/write priority
    ev_in = EV_BRANCH | EV_STALL;
    @(negedge clk);
    ev_in = '0;
    repeat (3) @(negedge clk);
    mem_access(1'b0, 1'b1, A_STALL, 16'hFFFF, 1'b1, 16'h0, "wr_stall");
    check("clr1_stall", {16'h0, bank[PERF_STALL]}, 32'd0);
    check("clr1_branch", {16'h0, bank[PERF_BRANCH]}, 32'd1);
    mem_access(1'b1, 1'b0, A_CTRL, 16'h0, 1'b1, 16'h0001, "rd_ctrl_keep");
    mem_access(1'b1, 1'b1, A_BRANCH, 16'h0, 1'b1, 16'h0000, "rw_branch");
    check("rw_cleared", {16'h0, bank[PERF_BRANCH]}, 32'd0);
    mem_access(1'b0, 1'b1, 16'hFFF6, 16'h0000, 1'b0, 16'h0, "wr_miss");
    mem_access(1'b1, 1'b0, A_CTRL, 16'h0, 1'b1, 16'h0001, "rd_ctrl_miss");

    // read concurrent with increment returns pre-increment value
    ev_in = EV_BRANCH;
    @(negedge clk);
    ev_in = '0;
    mem_access(1'b1, 1'b0, A_BRANCH, 16'h0, 1'b1, 16'd0, "rd_concur");
    check("concur_after", {16'h0, bank[PERF_BRANCH]}, 32'd1);

    // reset during ACK of a CTRL write
    mem_read = 1'b0; mem_write = 1'b1; mem_address = A_CTRL; mem_wdata = 16'h0000;
    @(negedge clk);
    check("rack_resp", {31'b0, mem_resp}, 32'h1);
    mem_write = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("rack_fsm", {31'b0, fsm_state}, {31'b0, PERF_IDLE});
    check("rack_resp_drop", {31'b0, mem_resp}, 32'h0);
    check("rack_load", {22'b0, ctr_load}, 32'h3FF);
    reset = 1'b0;
    @(negedge clk);
    check_bank_zero("rack_bank");
    mem_access(1'b1, 1'b0, A_CTRL, 16'h0, 1'b1, 16'h0001, "rack_ctrl");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
